spi_io_hub: RTL and testbench

Parametrised successor to the core's SPI user-I/O slave: it connects the IO controller's SPI link to `NUM_CH` generic byte channels in both directions, plus buttons/switches. SPI lines are oversampled in the core clock domain. Inbound bytes go through a per-channel FIFO. Outbound bytes use a core-side valid/ready handshake. It sits between the top-level SPI pins and the ACIA/MFP/PSG/MIDI peripherals, replacing their fixed strobe ports.

---
 rtl/spi_io_hub_pkg.sv | 26 ++
 rtl/spi_io_hub_if.sv | 17 +
 rtl/spi_io_hub_byte_fifo.sv | 57 +++++
 rtl/spi_io_hub.sv | 195 +++++++++++++++++++
 tb/tb_spi_io_hub.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_io_hub_pkg.sv
// Shared constants, frame states and status-byte layout for the SPI user-I/O hub.
package spi_io_pkg;

   localparam logic [7:0] CMD_BUT_SW  = 8'h01;
   localparam logic [7:0] CMD_WR_BASE = 8'h10;
   localparam logic [7:0] CMD_RD_BASE = 8'h20;

   localparam int unsigned STAT_VALID_BIT = 0;
   localparam int unsigned STAT_OVF_BIT   = 1;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      PAYLOAD,
      ABORT
   } frame_state_e;

   function automatic logic [7:0] status_byte(input logic ovf, input logic valid);
      logic [7:0] s;
      s                 = '0;
      s[STAT_OVF_BIT]   = ovf;
      s[STAT_VALID_BIT] = valid;
      return s;
   endfunction

endpackage

// File: rtl/spi_io_hub_if.sv
// Core-side byte channels: outbound valid/ready and inbound FIFO heads.
interface spi_io_hub_if #(parameter int unsigned NUM_CH = 4);

   logic [8*NUM_CH-1:0] in_data;
   logic [NUM_CH-1:0]   in_valid;
   logic [NUM_CH-1:0]   in_ready;
   logic [8*NUM_CH-1:0] out_data;
   logic [NUM_CH-1:0]   out_valid;
   logic [NUM_CH-1:0]   out_ready;

   modport master (output in_data, in_valid, out_ready,
                   input  in_ready, out_data, out_valid);

   modport slave  (input  in_data, in_valid, out_ready,
                   output in_ready, out_data, out_valid);

endinterface

// File: rtl/spi_io_hub_byte_fifo.sv
// Synchronous show-ahead byte FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = pop_i & ~empty_o;
      push_ok  = push_i & (~full_o | pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/spi_io_hub.sv
// SPI user-I/O hub: oversampled SPI slave bridging NUM_CH byte channels plus buttons/switches.
module spi_io_hub
   import spi_io_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_sck,
   input  logic        spi_ss,
   input  logic        spi_mosi,
   output logic        spi_miso,
   input  logic [7:0]  core_type,
   output logic [1:0]  buttons,
   output logic [1:0]  switches,
   spi_io_hub_if.slave ch
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [2:0]        sck_q;
   logic [1:0]        ss_q, mosi_q;
   frame_state_e      state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [6:0]        rx_q, rx_d;
   logic [7:0]        tx_q, tx_d, cmd_q, cmd_d, snap_data_q, snap_data_d;
   logic [7:0]        push_data_q, push_data_d;
   logic              miso_q, miso_d, phase_q, phase_d;
   logic              snap_valid_q, snap_valid_d, snap_ovf_q, snap_ovf_d;
   logic [3:0]        btn_sw_q, btn_sw_d;
   logic [NUM_CH-1:0] push_q, push_d, in_ready_q, in_ready_d, ovf_q, ovf_d;
   logic [NUM_CH-1:0] ovf_set, fifo_full;
   logic              sck_rise, sck_fall, wr_hit, rd_hit;
   logic [7:0]        rx_byte, load_byte, in_sel;
   logic [CH_W-1:0]   ch_idx;

   // Synchronisers come out of reset with ss low so an interrupted frame stays in ABORT.
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_q  <= '0;
         ss_q   <= '0;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[1:0], spi_sck};
         ss_q   <= {ss_q[0], spi_ss};
         mosi_q <= {mosi_q[0], spi_mosi};
      end
   end

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign ch_idx   = cmd_q[CH_W-1:0];
   assign wr_hit   = (cmd_q[7:4] == CMD_WR_BASE[7:4]) && (32'(cmd_q[3:0]) < NUM_CH);
   assign rd_hit   = (cmd_q[7:4] == CMD_RD_BASE[7:4]) && (32'(cmd_q[3:0]) < NUM_CH);

   always_comb begin
      rx_byte      = {rx_q, mosi_q[1]};
      in_sel       = ch.in_data[8*ch_idx +: 8];
      load_byte    = '0;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      miso_d       = miso_q;
      cmd_d        = cmd_q;
      phase_d      = phase_q;
      snap_valid_d = snap_valid_q;
      snap_data_d  = snap_data_q;
      snap_ovf_d   = snap_ovf_q;
      btn_sw_d     = btn_sw_q;
      push_d       = '0;
      push_data_d  = push_data_q;
      in_ready_d   = '0;
      ovf_d        = ovf_q | ovf_set;

      // phase_q: 0 = status byte, 1 = data byte of a read-channel payload pair
      if (state_q == PAYLOAD && rd_hit)
         load_byte = phase_q ? (snap_valid_q ? snap_data_q : '0)
                             : status_byte(ovf_q[ch_idx], ch.in_valid[ch_idx]);

      case (state_q)
         IDLE: begin
            if (!ss_q[1]) begin
               state_d   = CMD;
               bit_cnt_d = '0;
               miso_d    = core_type[7];
               tx_d      = {core_type[6:0], 1'b0};
            end
         end
         CMD, PAYLOAD: begin
            if (ss_q[1]) begin
               state_d = IDLE;
            end else if (sck_rise) begin
               rx_d      = rx_byte[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (state_q == CMD) begin
                     cmd_d   = rx_byte;
                     phase_d = 1'b0;
                     state_d = PAYLOAD;
                  end else begin
                     phase_d = ~phase_q;
                     if (cmd_q == CMD_BUT_SW) btn_sw_d = rx_byte[3:0];
                     if (wr_hit) begin
                        push_d[ch_idx] = 1'b1;
                        push_data_d    = rx_byte;
                     end
                     if (rd_hit) begin
                        if (phase_q)         in_ready_d[ch_idx] = snap_valid_q;
                        else if (snap_ovf_q) ovf_d[ch_idx]      = 1'b0;
                     end
                  end
               end
            end else if (sck_fall) begin
               if (bit_cnt_q == 3'd0) begin
                  miso_d = load_byte[7];
                  tx_d   = {load_byte[6:0], 1'b0};
                  if (state_q == PAYLOAD && rd_hit && !phase_q) begin
                     snap_valid_d = ch.in_valid[ch_idx];
                     snap_data_d  = in_sel;
                     snap_ovf_d   = ovf_q[ch_idx];
                  end
               end else begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
            end
         end
         ABORT: begin
            if (ss_q[1]) state_d = IDLE;
         end
         default: state_d = ABORT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ABORT;
         bit_cnt_q    <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         miso_q       <= 1'b0;
         cmd_q        <= '0;
         phase_q      <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_data_q  <= '0;
         snap_ovf_q   <= 1'b0;
         btn_sw_q     <= '0;
         push_q       <= '0;
         push_data_q  <= '0;
         in_ready_q   <= '0;
         ovf_q        <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         miso_q       <= miso_d;
         cmd_q        <= cmd_d;
         phase_q      <= phase_d;
         snap_valid_q <= snap_valid_d;
         snap_data_q  <= snap_data_d;
         snap_ovf_q   <= snap_ovf_d;
         btn_sw_q     <= btn_sw_d;
         push_q       <= push_d;
         push_data_q  <= push_data_d;
         in_ready_q   <= in_ready_d;
         ovf_q        <= ovf_d;
      end
   end

   assign spi_miso    = miso_q;
   assign buttons     = btn_sw_q[1:0];
   assign switches    = btn_sw_q[3:2];
   assign ch.in_ready = in_ready_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic empty;
      byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .push_i  (push_q[k]),
         .data_i  (push_data_q),
         .pop_i   (ch.out_ready[k]),
         .data_o  (ch.out_data[8*k +: 8]),
         .full_o  (fifo_full[k]),
         .empty_o (empty)
      );
      assign ch.out_valid[k] = ~empty;
      // A full FIFO only drops when the core is not popping it this cycle
      assign ovf_set[k] = push_q[k] & fifo_full[k] & ~ch.out_ready[k];
   end

endmodule

// File: tb/tb_spi_io_hub.sv
// Directed self-checking bench for spi_io_hub driving a slow SPI master against hand-computed bytes.
module tb_spi_io_hub;

   localparam int unsigned NCH = 4;

   logic       clk = 1'b0;
   logic       reset, sck, ss, mosi, miso;
   logic [7:0] core_type;
   logic [1:0] buttons, switches;
   int         tests = 0;
   int         fails = 0;
   int         rdy_cnt [NCH];

   spi_io_hub_if #(.NUM_CH(NCH)) bus ();

   spi_io_hub #(.NUM_CH(NCH), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .spi_sck   (sck),
      .spi_ss    (ss),
      .spi_mosi  (mosi),
      .spi_miso  (miso),
      .core_type (core_type),
      .buttons   (buttons),
      .switches  (switches),
      .ch        (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      for (int k = 0; k < NCH; k++) if (bus.in_ready[k] === 1'b1) rdy_cnt[k]++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic half();
      repeat (8) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         half();
         rx  = {rx[6:0], miso};
         sck = 1'b1;
         half();
         sck = 1'b0;
      end
   endtask

   task automatic frame_start();
      ss = 1'b0;
      half();
   endtask

   task automatic frame_end();
      half();
      ss = 1'b1;
      half();
      half();
   endtask

   task automatic test_reset();
      reset = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; core_type = 8'hA5;
      bus.in_data = '0; bus.in_valid = '0; bus.out_ready = '0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso got=%b exp=0", miso); end
      tests++; if (buttons !== 2'b00) begin fails++; $display("FAIL reset_buttons got=%b exp=00", buttons); end
      tests++; if (switches !== 2'b00) begin fails++; $display("FAIL reset_switches got=%b exp=00", switches); end
      tests++; if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL reset_out_valid got=%b exp=0000", bus.out_valid); end
      tests++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
   endtask

   task automatic test_buttons();
      logic [7:0] r0, r1;
      frame_start();
      xfer(8'h01, 8, r0);
      xfer(8'h0B, 8, r1);
      frame_end();
      tests++; if (r0 !== 8'hA5) begin fails++; $display("FAIL but_core_type got=%h exp=a5", r0); end
      tests++; if (buttons !== 2'b11) begin fails++; $display("FAIL but_buttons got=%b exp=11", buttons); end
      tests++; if (switches !== 2'b10) begin fails++; $display("FAIL but_switches got=%b exp=10", switches); end
   endtask

   task automatic test_write_fifo();
      logic [7:0] r;
      frame_start();
      xfer(8'h12, 8, r);
      xfer(8'h41, 8, r);
      xfer(8'h42, 8, r);
      frame_end();
      tests++; if (bus.out_valid !== 4'b0100) begin fails++; $display("FAIL wr_valid got=%b exp=0100", bus.out_valid); end
      tests++; if (bus.out_data[23:16] !== 8'h41) begin fails++; $display("FAIL wr_head0 got=%h exp=41", bus.out_data[23:16]); end
      bus.out_ready[2] = 1'b1;
      @(negedge clk);
      tests++; if (bus.out_data[23:16] !== 8'h42 || bus.out_valid[2] !== 1'b1) begin
         fails++; $display("FAIL wr_head1 got=%h/%b exp=42/1", bus.out_data[23:16], bus.out_valid[2]); end
      @(negedge clk);
      bus.out_ready[2] = 1'b0;
      tests++; if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL wr_drained got=%b exp=0000", bus.out_valid); end
   endtask

   task automatic test_overflow();
      logic [7:0] r, exp_b;
      logic [7:0] st [3];
      frame_start();
      xfer(8'h10, 8, r);
      for (int i = 0; i < 6; i++) begin
         exp_b = 8'hA0 + 8'(i);
         xfer(exp_b, 8, r);
      end
      frame_end();
      tests++; if (bus.out_valid !== 4'b0001) begin fails++; $display("FAIL ovf_valid got=%b exp=0001", bus.out_valid); end
      frame_start();
      xfer(8'h20, 8, r);
      for (int i = 0; i < 3; i++) xfer(8'h00, 8, st[i]);
      frame_end();
      tests++; if (st[0] !== 8'h02) begin fails++; $display("FAIL ovf_status got=%h exp=02", st[0]); end
      tests++; if (st[1] !== 8'h00) begin fails++; $display("FAIL ovf_data got=%h exp=00", st[1]); end
      tests++; if (st[2] !== 8'h00) begin fails++; $display("FAIL ovf_status_cleared got=%h exp=00", st[2]); end
      bus.out_ready[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_b = 8'hA0 + 8'(i);
         tests++; if (bus.out_data[7:0] !== exp_b) begin
            fails++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus.out_data[7:0], exp_b); end
         @(negedge clk);
      end
      bus.out_ready[0] = 1'b0;
      tests++; if (bus.out_valid[0] !== 1'b0) begin fails++; $display("FAIL ovf_empty got=%b exp=0", bus.out_valid[0]); end
   endtask

   task automatic test_read_channel();
      logic [7:0] r;
      logic [7:0] st [4];
      int base0, base1, other0, other1;
      bus.in_data[15:8] = 8'h7E;
      bus.in_valid[1]   = 1'b1;
      base0  = rdy_cnt[1];
      other0 = rdy_cnt[0] + rdy_cnt[2] + rdy_cnt[3];
      frame_start();
      xfer(8'h21, 8, r);
      fork
         for (int i = 0; i < 4; i++) xfer(8'h00, 8, st[i]);
         for (int c = 0; c < 400 && bus.in_valid[1] === 1'b1; c++) begin
            @(negedge clk);
            if (bus.in_ready[1] === 1'b1) bus.in_valid[1] = 1'b0;
         end
      join
      frame_end();
      base1  = rdy_cnt[1];
      other1 = rdy_cnt[0] + rdy_cnt[2] + rdy_cnt[3];
      tests++; if (r !== 8'hA5) begin fails++; $display("FAIL rd_core_type got=%h exp=a5", r); end
      tests++; if (st[0] !== 8'h01) begin fails++; $display("FAIL rd_status0 got=%h exp=01", st[0]); end
      tests++; if (st[1] !== 8'h7E) begin fails++; $display("FAIL rd_data0 got=%h exp=7e", st[1]); end
      tests++; if (st[2] !== 8'h00) begin fails++; $display("FAIL rd_status1 got=%h exp=00", st[2]); end
      tests++; if (st[3] !== 8'h00) begin fails++; $display("FAIL rd_data1 got=%h exp=00", st[3]); end
      tests++; if (base1 - base0 !== 1) begin fails++; $display("FAIL rd_ready_cycles got=%0d exp=1", base1 - base0); end
      tests++; if (other1 - other0 !== 0) begin fails++; $display("FAIL rd_ready_other got=%0d exp=0", other1 - other0); end
   endtask

   task automatic test_invalid_cmd();
      logic [7:0] r0, r1;
      frame_start();
      xfer(8'h24, 8, r0);
      xfer(8'h00, 8, r1);
      frame_end();
      tests++; if (r1 !== 8'h00) begin fails++; $display("FAIL inv_rd4_miso got=%h exp=00", r1); end
      frame_start();
      xfer(8'h14, 8, r0);
      xfer(8'h33, 8, r1);
      frame_end();
      tests++; if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL inv_wr4_valid got=%b exp=0000", bus.out_valid); end
      tests++; if (r1 !== 8'h00) begin fails++; $display("FAIL inv_wr4_miso got=%h exp=00", r1); end
   endtask

   task automatic test_partial();
      logic [7:0] r;
      frame_start();
      xfer(8'h13, 8, r);
      xfer(8'h5A, 5, r);
      frame_end();
      tests++; if (bus.out_valid[3] !== 1'b0) begin fails++; $display("FAIL part_nopush got=%b exp=0", bus.out_valid[3]); end
      frame_start();
      xfer(8'h13, 8, r);
      xfer(8'h5A, 8, r);
      frame_end();
      tests++; if (bus.out_valid[3] !== 1'b1 || bus.out_data[31:24] !== 8'h5A) begin
         fails++; $display("FAIL part_next got=%b/%h exp=1/5a", bus.out_valid[3], bus.out_data[31:24]); end
      bus.out_ready[3] = 1'b1;
      @(negedge clk);
      bus.out_ready[3] = 1'b0;
   endtask

   task automatic test_reset_midframe();
      logic [7:0] r, r2;
      frame_start();
      xfer(8'h01, 8, r);
      xfer(8'h0F, 8, r);
      frame_end();
      tests++; if ({switches, buttons} !== 4'hF) begin fails++; $display("FAIL mid_pre_btn got=%h exp=f", {switches, buttons}); end
      frame_start();
      xfer(8'h11, 8, r);
      xfer(8'h55, 8, r);
      half();
      tests++; if (bus.out_valid[1] !== 1'b1) begin fails++; $display("FAIL mid_pre_push got=%b exp=1", bus.out_valid[1]); end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if ({switches, buttons} !== 4'h0) begin fails++; $display("FAIL mid_rst_btn got=%h exp=0", {switches, buttons}); end
      tests++; if (bus.out_valid !== 4'b0000) begin fails++; $display("FAIL mid_rst_valid got=%b exp=0000", bus.out_valid); end
      tests++; if (miso !== 1'b0) begin fails++; $display("FAIL mid_rst_miso got=%b exp=0", miso); end
      xfer(8'h01, 8, r);
      xfer(8'h0F, 8, r2);
      frame_end();
      tests++; if ({switches, buttons} !== 4'h0) begin fails++; $display("FAIL mid_ignored_btn got=%h exp=0", {switches, buttons}); end
      tests++; if (r !== 8'h00 || r2 !== 8'h00) begin fails++; $display("FAIL mid_ignored_miso got=%h/%h exp=00/00", r, r2); end
      frame_start();
      xfer(8'h11, 8, r);
      xfer(8'h99, 8, r);
      frame_end();
      tests++; if (bus.out_valid !== 4'b0010 || bus.out_data[15:8] !== 8'h99) begin
         fails++; $display("FAIL mid_next got=%b/%h exp=0010/99", bus.out_valid, bus.out_data[15:8]); end
   endtask

   initial begin
      for (int k = 0; k < NCH; k++) rdy_cnt[k] = 0;
      test_reset();
      test_buttons();
      test_write_fifo();
      test_overflow();
      test_read_channel();
      test_invalid_cmd();
      test_partial();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
